// File: rtl/fir_io_pkg.sv
// rtl/fir_io_pkg.sv - shared state type, pin map and default widths for the FIR pin host
package fir_io_pkg;

   typedef enum logic [1:0] {
      ST_DUT_RST = 2'd0,
      ST_IDLE    = 2'd1,
      ST_PH_LO   = 2'd2,
      ST_PH_HI   = 2'd3
   } fir_io_state_e;

   localparam int IO_CLK_BIT = 0;
   localparam int IO_RST_BIT = 1;
   localparam int IO_X_LSB   = 2;

   localparam int FIR_BW_IN  = 6;
   localparam int FIR_BW_OUT = 8;

endpackage

// File: rtl/fir_io_fifo.sv
// rtl/fir_io_fifo.sv - first-word fall-through result buffer with synchronous flush
module fir_io_fifo
   import fir_io_pkg::*;
#(
   parameter int WIDTH = FIR_BW_OUT,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] push_data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] pop_data_o,
   output logic             empty_o,
   output logic             full_o
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_q;
   logic [AW-1:0]    rd_q;
   logic [AW:0]      cnt_q;
   logic             do_push;
   logic             do_pop;

   function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
   endfunction

   assign empty_o    = (cnt_q == '0);
   assign full_o     = (cnt_q == (AW+1)'(DEPTH));
   assign pop_data_o = mem_q[rd_q];
   assign do_pop     = pop_i && !empty_o;
   // a pop frees the slot in the same cycle, so push-while-full is accepted
   assign do_push    = push_i && (!full_o || do_pop);

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_q] <= push_data_i;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else if (flush_i) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (do_push) begin
            wr_q <= ptr_inc(wr_q);
         end
         if (do_pop) begin
            rd_q <= ptr_inc(rd_q);
         end
         case ({do_push, do_pop})
            2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
            2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
            default: cnt_q <= cnt_q;
         endcase
      end
   end

endmodule

// File: rtl/fir_io_host.sv
// rtl/fir_io_host.sv - drives {x, rst, clk} onto a TinyTapeout FIR and streams results back
// Optional FIR_IO_HOST_STATS_EN adds a 16-bit sample_count output.
module fir_io_host
   import fir_io_pkg::*;
#(
   parameter int BW_in      = FIR_BW_IN,
   parameter int BW_out     = FIR_BW_OUT,
   parameter int CLK_DIV    = 4,
   parameter int RST_CYCLES = 2,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [BW_in-1:0]  s_data,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [BW_out-1:0] m_data,
   input  logic              dut_rst_req,
   output logic [7:0]        io_in,
   input  logic [7:0]        io_out,
`ifdef FIR_IO_HOST_STATS_EN
   output logic [15:0]       sample_count,
`endif
   output logic              busy
);

   localparam int DW     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int HALVES = 2 * RST_CYCLES;
   localparam int HW     = (HALVES > 1) ? $clog2(HALVES) : 1;
   localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
   localparam logic [HW-1:0] HALF_LAST = HW'(HALVES - 1);
   localparam logic [7:0]    IO_RESET  = 8'b1 << IO_RST_BIT;

   fir_io_state_e state_q, state_d;
   logic [DW-1:0] div_q, div_d;
   logic [HW-1:0] half_q, half_d;
   logic [7:0]    io_q, io_d;
   logic          pend_q, pend_d;
   logic          div_last;
   logic          rst_req_eff;
   logic          ready_c;
   logic          fifo_push;
   logic          fifo_flush;
   logic          fifo_full;
   logic          fifo_empty;

   assign div_last    = (div_q == DIV_LAST);
   assign rst_req_eff = dut_rst_req || pend_q;

   always_comb begin
      state_d    = state_q;
      div_d      = div_q;
      half_d     = half_q;
      io_d       = io_q;
      pend_d     = pend_q;
      ready_c    = 1'b0;
      fifo_push  = 1'b0;
      fifo_flush = 1'b0;
      case (state_q)
         ST_DUT_RST: begin
            div_d = div_last ? '0 : div_q + DW'(1);
            if (div_last) begin
               if (half_q == HALF_LAST) begin
                  state_d = ST_IDLE;
                  io_d    = '0;
                  half_d  = '0;
               end else begin
                  io_d[IO_CLK_BIT] = ~io_q[IO_CLK_BIT];
                  half_d           = half_q + HW'(1);
               end
            end
         end
         ST_IDLE: begin
            ready_c = !fifo_full && !rst_req_eff;
            if (rst_req_eff) begin
               state_d    = ST_DUT_RST;
               io_d       = IO_RESET;
               div_d      = '0;
               half_d     = '0;
               pend_d     = 1'b0;
               fifo_flush = 1'b1;
            end else if (s_valid && ready_c) begin
               io_d                      = '0;
               io_d[IO_X_LSB +: BW_in]   = s_data;
               state_d                   = ST_PH_LO;
               div_d                     = '0;
            end
         end
         ST_PH_LO: begin
            pend_d = pend_q || dut_rst_req;
            div_d  = div_last ? '0 : div_q + DW'(1);
            if (div_last) begin
               state_d          = ST_PH_HI;
               io_d[IO_CLK_BIT] = 1'b1;
            end
         end
         ST_PH_HI: begin
            pend_d = pend_q || dut_rst_req;
            div_d  = div_last ? '0 : div_q + DW'(1);
            // the DUT output settled after the rising edge; capture just before falling
            if (div_last) begin
               fifo_push        = 1'b1;
               state_d          = ST_IDLE;
               io_d[IO_CLK_BIT] = 1'b0;
            end
         end
         default: begin
            state_d = ST_DUT_RST;
            io_d    = IO_RESET;
            div_d   = '0;
            half_d  = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_DUT_RST;
         div_q   <= '0;
         half_q  <= '0;
         io_q    <= IO_RESET;
         pend_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         half_q  <= half_d;
         io_q    <= io_d;
         pend_q  <= pend_d;
      end
   end

   fir_io_fifo #(
      .WIDTH (BW_out),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk         (clk),
      .rst         (rst),
      .flush_i     (fifo_flush),
      .push_i      (fifo_push),
      .push_data_i (io_out[BW_out-1:0]),
      .pop_i       (m_valid && m_ready),
      .pop_data_o  (m_data),
      .empty_o     (fifo_empty),
      .full_o      (fifo_full)
   );

`ifdef FIR_IO_HOST_STATS_EN
   logic [15:0] cnt_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
      end else if (fifo_flush) begin
         cnt_q <= '0;
      end else if (fifo_push) begin
         cnt_q <= cnt_q + 16'd1;
      end
   end

   assign sample_count = cnt_q;
`endif

   assign s_ready = ready_c;
   assign m_valid = !fifo_empty;
   assign io_in   = io_q;
   assign busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_fir_io_host.sv
// tb/tb_fir_io_host.sv - randomized bench for fir_io_host against a pin-level FIR model and scoreboard
module tb_fir_io_host;

   localparam int BW_IN      = 6;
   localparam int BW_OUT     = 8;
   localparam int CLK_DIV    = 2;
   localparam int RST_CYCLES = 2;
   localparam int FIFO_DEPTH = 4;
   localparam int RST_LEN    = 2 * CLK_DIV * RST_CYCLES;

   logic              clk         = 1'b0;
   logic              rst         = 1'b0;
   logic              s_valid     = 1'b0;
   logic              s_ready;
   logic [BW_IN-1:0]  s_data      = '0;
   logic              m_valid;
   logic              m_ready     = 1'b0;
   logic [BW_OUT-1:0] m_data;
   logic              dut_rst_req = 1'b0;
   logic [7:0]        io_in;
   logic [7:0]        io_out      = 8'h00;
   logic              busy;
`ifdef FIR_IO_HOST_STATS_EN
   logic [15:0]       sample_count;
`endif

   int         checks = 0;
   int         errors = 0;
   logic [7:0] exp_q[$];
   logic       hs_seen = 1'b0;
   logic [5:0] hs_x    = '0;
   int         n_acc   = 0;
   int         n_pop   = 0;

   always #5 clk = ~clk;

   fir_io_host #(
      .BW_in      (BW_IN),
      .BW_out     (BW_OUT),
      .CLK_DIV    (CLK_DIV),
      .RST_CYCLES (RST_CYCLES),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_dut (
      .clk          (clk),
      .rst          (rst),
      .s_valid      (s_valid),
      .s_ready      (s_ready),
      .s_data       (s_data),
      .m_valid      (m_valid),
      .m_ready      (m_ready),
      .m_data       (m_data),
      .dut_rst_req  (dut_rst_req),
      .io_in        (io_in),
      .io_out       (io_out),
`ifdef FIR_IO_HOST_STATS_EN
      .sample_count (sample_count),
`endif
      .busy         (busy)
   );

   function automatic logic [7:0] fir_ref(input logic [5:0] x);
      return {{2{x[5]}}, x} + 8'd1;
   endfunction

   // registered FIR stand-in: y = sext(x) + 1 on each DUT clock rise
   always @(posedge io_in[0]) begin
      io_out <= io_in[1] ? 8'h00 : fir_ref(io_in[7:2]);
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got 0x%0h want 0x%0h", tag, got, want);
      end
   endtask

   task automatic step();
      #1;
      hs_seen = 1'b0;
      if (s_valid && s_ready) begin
         exp_q.push_back(fir_ref(s_data));
         hs_seen = 1'b1;
         hs_x    = s_data;
         n_acc++;
      end
      if (m_valid && m_ready) begin
         n_pop++;
         chk("pop_has_expect", 32'(exp_q.size() != 0), 1);
         if (exp_q.size() != 0) chk("m_data", 32'(m_data), 32'(exp_q.pop_front()));
      end
      @(posedge clk);
      #1;
      if (hs_seen) chk("io_x", 32'(io_in[7:2]), 32'(hs_x));
   endtask

   task automatic wait_dut_rst(output int len, output int rises);
      logic prev;
      prev  = 1'b0;
      len   = 0;
      rises = 0;
      for (int i = 0; i < 64; i++) begin
         if (!(io_in[1] && io_in[7:2] == 6'd0)) break;
         len++;
         if (io_in[0] && !prev) rises++;
         prev = io_in[0];
         step();
      end
   endtask

   task automatic wait_mvalid(input int budget);
      for (int i = 0; i < budget && !m_valid; i++) step();
      chk("m_valid_timeout", 32'(m_valid), 1);
   endtask

   task automatic drain(input int budget);
      m_ready = 1'b1;
      for (int i = 0; i < budget && (exp_q.size() != 0 || busy); i++) step();
      m_ready = 1'b0;
      chk("drain_left", exp_q.size(), 0);
      chk("drain_m_valid", 32'(m_valid), 0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      int len, rises, a0, a1, p0, cnt, stall_rdy;
      logic [3:0] pat;
      logic prev;

      // reset and DUT reset sequence
      repeat (3) @(posedge clk);
      #1;
      chk("rst_io_in", 32'(io_in), 'h02);
      chk("rst_busy", 32'(busy), 1);
      chk("rst_s_ready", 32'(s_ready), 0);
      chk("rst_m_valid", 32'(m_valid), 0);
      rst = 1'b1;
      wait_dut_rst(len, rises);
      chk("rst_len", len, RST_LEN);
      chk("rst_rises", rises, RST_CYCLES);
      chk("idle_io_in", 32'(io_in), 0);
      chk("idle_busy", 32'(busy), 0);
      chk("idle_s_ready", 32'(s_ready), 1);
`ifdef FIR_IO_HOST_STATS_EN
      chk("stats_rst", 32'(sample_count), 0);
`endif

      // single sample and its latency
      s_valid = 1'b1;
      s_data  = 6'd5;
      step();
      s_valid = 1'b0;
      chk("single_io_x", 32'(io_in[7:2]), 5);
      cnt = 0;
      pat = '0;
      for (int i = 0; i < 4; i++) begin
         cnt += int'(m_valid);
         pat  = {pat[2:0], io_in[0]};
         step();
      end
      chk("single_early_valid", cnt, 0);
      chk("single_dut_clk", 32'(pat), 'b0011);
      chk("single_m_valid", 32'(m_valid), 1);
      chk("single_m_data", 32'(m_data), 6);
      drain(20);

      // negative full scale
      s_valid = 1'b1;
      s_data  = 6'b100000;
      step();
      s_valid = 1'b0;
      chk("negfs_io_x", 32'(io_in[7:2]), 'h20);
      wait_mvalid(20);
      chk("negfs_m_data", 32'(m_data), 'hE1);
      drain(20);

      // back-pressure with the output stalled
      m_ready   = 1'b0;
      s_valid   = 1'b1;
      s_data    = 6'($urandom);
      a0        = n_acc;
      rises     = 0;
      stall_rdy = 0;
      prev      = io_in[0];
      for (int i = 0; i < 60; i++) begin
         a1 = n_acc;
         step();
         if (n_acc != a1) s_data = 6'($urandom);
         if (i >= 30) begin
            if (io_in[0] && !prev) rises++;
            if (s_ready) stall_rdy++;
         end
         prev = io_in[0];
      end
      chk("bp_accepted", n_acc - a0, FIFO_DEPTH);
      chk("bp_stall_ready", stall_rdy, 0);
      chk("bp_stall_clk", rises, 0);
      m_ready = 1'b1;
      step();
      m_ready = 1'b0;
      a1 = n_acc;
      for (int i = 0; i < 10 && n_acc == a1; i++) step();
      s_valid = 1'b0;
      chk("bp_fifth", n_acc - a1, 1);
      drain(100);

      // re-reset requested while the DUT clock is high
      s_valid = 1'b1;
      s_data  = 6'($urandom);
      step();
      s_valid = 1'b0;
      step();
      step();
      chk("rr_in_ph_hi", 32'(io_in[0]), 1);
      dut_rst_req = 1'b1;
      step();
      dut_rst_req = 1'b0;
      step();
      chk("rr_cap_valid", 32'(m_valid), 1);
      chk("rr_cap_data", 32'(m_data), 32'(exp_q[0]));
      chk("rr_cap_ready", 32'(s_ready), 0);
      step();
      exp_q.delete();
      chk("rr_flushed", 32'(m_valid), 0);
      wait_dut_rst(len, rises);
      chk("rr_len", len, RST_LEN);
      chk("rr_idle", 32'(busy), 0);
`ifdef FIR_IO_HOST_STATS_EN
      chk("stats_after_rr", 32'(sample_count), 0);
`endif

      // three samples, then a reset request racing a valid sample
      a0      = n_acc;
      s_valid = 1'b1;
      s_data  = 6'($urandom);
      for (int i = 0; i < 60 && (n_acc - a0) < 3; i++) begin
         a1 = n_acc;
         step();
         if (n_acc != a1) s_data = 6'($urandom);
      end
      s_valid = 1'b0;
      chk("three_accepted", n_acc - a0, 3);
      drain(50);
`ifdef FIR_IO_HOST_STATS_EN
      chk("stats_three", 32'(sample_count), 3);
`endif
      s_valid     = 1'b1;
      s_data      = 6'h15;
      dut_rst_req = 1'b1;
      #1;
      chk("prio_s_ready", 32'(s_ready), 0);
      step();
      s_valid     = 1'b0;
      dut_rst_req = 1'b0;
      chk("prio_busy", 32'(busy), 1);
      chk("prio_io_in", 32'(io_in), 'h02);
`ifdef FIR_IO_HOST_STATS_EN
      chk("stats_clear", 32'(sample_count), 0);
`endif
      wait_dut_rst(len, rises);
      chk("prio_len", len, RST_LEN);

      // randomized traffic against the scoreboard
      a0 = n_acc;
      p0 = n_pop;
      for (int i = 0; i < 400; i++) begin
         s_valid = ($urandom_range(0, 9) < 7);
         s_data  = 6'($urandom);
         m_ready = 1'($urandom_range(0, 1));
         step();
      end
      s_valid = 1'b0;
      drain(200);
      chk("rand_balance", n_pop - p0, n_acc - a0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
